// File: rtl/uart_rx_if.sv
// Bus-side register interface of the UART receiver: received byte, status levels and consume pulse.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_ack;

  modport master (output rx_data, rx_avail, rx_error, input rx_ack);
  modport slave  (input rx_data, rx_avail, rx_error, output rx_ack);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, overrun and framing-error flags.
module uart_rx #(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     uart_rxd,
  uart_rx_if.master bus
);
  localparam int DIV_RAW = freq_hz / (16 * baud);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic [1:0]    sync;
  logic          rxd_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state, state_nx;
  logic [3:0]    cnt16, cnt16_nx;
  logic [2:0]    bitcnt, bitcnt_nx;
  logic [7:0]    sreg, sreg_nx;
  logic          frame_ok, frame_err;

  assign rxd_s = sync[1];
  assign tick  = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= 2'b11;
      div_cnt <= '0;
      state   <= IDLE;
      cnt16   <= '0;
      bitcnt  <= '0;
      sreg    <= '0;
    end else begin
      sync    <= {sync[0], uart_rxd};
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      state   <= state_nx;
      cnt16   <= cnt16_nx;
      bitcnt  <= bitcnt_nx;
      sreg    <= sreg_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt16_nx  = cnt16;
    bitcnt_nx = bitcnt;
    sreg_nx   = sreg;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    if (tick) begin
      case (state)
        IDLE:
          if (!rxd_s) begin
            state_nx = START;
            cnt16_nx = 4'd0;
          end
        START:
          // Re-check the line at mid start bit so short glitches are dropped.
          if (cnt16 == 4'd7) begin
            if (!rxd_s) begin
              state_nx  = DATA;
              cnt16_nx  = 4'd0;
              bitcnt_nx = 3'd0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt16_nx = cnt16 + 4'd1;
          end
        DATA: begin
          cnt16_nx = cnt16 + 4'd1;
          if (cnt16 == 4'd15) begin
            sreg_nx   = {rxd_s, sreg[7:1]};
            bitcnt_nx = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state_nx = STOP;
              cnt16_nx = 4'd0;
            end
          end
        end
        STOP: begin
          cnt16_nx = cnt16 + 4'd1;
          if (cnt16 == 4'd15) begin
            if (rxd_s) begin
              frame_ok = 1'b1;
              state_nx = IDLE;
            end else begin
              frame_err = 1'b1;
              state_nx  = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH:
          if (rxd_s) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // A consume pulse landing with a new event is superseded by that event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rx_data  <= 8'h00;
      bus.rx_avail <= 1'b0;
      bus.rx_error <= 1'b0;
    end else if (frame_ok) begin
      bus.rx_data  <= sreg;
      bus.rx_avail <= 1'b1;
      bus.rx_error <= ~bus.rx_ack & (bus.rx_error | bus.rx_avail);
    end else if (frame_err) begin
      bus.rx_avail <= bus.rx_avail & ~bus.rx_ack;
      bus.rx_error <= 1'b1;
    end else if (bus.rx_ack) begin
      bus.rx_avail <= 1'b0;
      bus.rx_error <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 32 clk/bit; expected output snapshots come from a frame-level model.
module tb_uart_rx;
  localparam int FREQ   = 3200000;
  localparam int BAUD   = 100000;
  localparam int BITCLK = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rxd = 1'b1;

  uart_rx_if bus();
  uart_rx #(.freq_hz(FREQ), .baud(BAUD)) dut (
    .clk(clk), .reset(reset), .uart_rxd(rxd), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] m;  // model state {avail, error, data}

  function automatic logic [9:0] outs();
    return {bus.rx_avail, bus.rx_error, bus.rx_data};
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got avail=%b err=%b data=%h, want avail=%b err=%b data=%h",
               name, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
    end
  endtask

  // Model pushes a snapshot only when the visible state is expected to change.
  task automatic m_push(logic [9:0] nx);
    if (nx !== m) exp_q.push_back(nx);
    m = nx;
  endtask
  task automatic m_frame(logic [7:0] b, bit ack);
    m_push({1'b1, (ack ? 1'b0 : (m[9] | m[8])), b});
  endtask
  task automatic m_ferr();
    m_push({m[9], 1'b1, m[7:0]});
  endtask
  task automatic m_ack();
    m_push({2'b00, m[7:0]});
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    while (cyc[0]) step(1);
  endtask

  task automatic send_frame(logic [7:0] b, logic stopv, int stop_len, int gap);
    align();
    rxd = 1'b0;
    step(BITCLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(BITCLK);
    end
    rxd = stopv;
    step(stop_len);
    rxd = 1'b1;
    step(gap);
  endtask

  task automatic do_ack();
    m_ack();
    bus.rx_ack = 1'b1;
    step(1);
    bus.rx_ack = 1'b0;
    step(2);
  endtask

  // Monitor: every visible change of the outputs consumes one expected snapshot.
  initial begin
    logic [9:0] prev, cur;
    prev = outs();
    forever begin
      @(negedge clk);
      cur = outs();
      if (!reset) prev = cur;
      else if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_change: got %h, want no change from %h", cur, prev);
        end else begin
          check("event", cur, exp_q.pop_front());
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bus.rx_ack = 1'b0;
    m = 10'h000;
    step(4);
    check("reset_state", outs(), 10'h000);
    reset = 1'b1;
    step(4);

    // Valid frame; also measure start-edge to rx_avail latency in clocks.
    m_frame(8'h55, 1'b0);
    align();
    fork
      send_frame(8'h55, 1'b1, BITCLK, 8);
      begin
        int n;
        n = 0;
        while (bus.rx_avail !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        lat = n - 1;
      end
    join
    n_cmp++;
    if (lat < 300 || lat > 320) begin
      n_bad++;
      $display("FAIL latency: got %0d clk, want 300..320", lat);
    end
    check("frame_55", outs(), {2'b10, 8'h55});
    do_ack();
    check("ack_55", outs(), {2'b00, 8'h55});

    // Short low glitch is rejected.
    rxd = 1'b0;
    step(8);
    rxd = 1'b1;
    step(100);
    check("glitch", outs(), {2'b00, 8'h55});

    // Framing error with a long low stop, then recovery.
    m_ferr();
    send_frame(8'hA3, 1'b0, 64, 16);
    check("framing", outs(), {2'b01, 8'h55});
    do_ack();
    m_frame(8'h0F, 1'b0);
    send_frame(8'h0F, 1'b1, BITCLK, 8);
    check("frame_0f", outs(), {2'b10, 8'h0F});
    do_ack();
    do_ack();
    check("ack_idle", outs(), {2'b00, 8'h0F});

    // Overrun from back-to-back frames.
    m_frame(8'h12, 1'b0);
    send_frame(8'h12, 1'b1, BITCLK, 0);
    m_frame(8'h34, 1'b0);
    send_frame(8'h34, 1'b1, BITCLK, 8);
    check("overrun", outs(), {2'b11, 8'h34});
    do_ack();
    check("overrun_ack", outs(), {2'b00, 8'h34});

    // Consume pulse coincident with a new frame completion.
    m_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, BITCLK, 8);
    m_frame(8'h7E, 1'b1);
    align();
    fork
      send_frame(8'h7E, 1'b1, BITCLK, 8);
      begin
        step(lat - 1);
        bus.rx_ack = 1'b1;
        step(1);
        bus.rx_ack = 1'b0;
      end
    join
    check("ack_coincident", outs(), {2'b10, 8'h7E});
    do_ack();

    // Reset during bit 4 abandons the frame.
    b = 8'hA5;
    align();
    rxd = 1'b0;
    step(BITCLK);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      step(BITCLK);
    end
    rxd = b[4];
    step(16);
    reset = 1'b0;
    exp_q.delete();
    m = 10'h000;
    rxd = 1'b1;
    step(20);
    check("reset_midframe", outs(), 10'h000);
    reset = 1'b1;
    step(40);
    m_frame(8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1, BITCLK, 8);
    check("frame_c3", outs(), {2'b10, 8'hC3});
    do_ack();

    // Randomized frames, framing errors and acks.
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        m_ferr();
        send_frame(b, 1'b0, BITCLK, $urandom_range(8, 40));
      end else begin
        m_frame(b, 1'b0);
        send_frame(b, 1'b1, BITCLK, $urandom_range(0, 40));
      end
      if ($urandom_range(0, 2) != 0) do_ack();
    end

    step(50);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d left, want 0", exp_q.size());
    end
    check("final_state", outs(), m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
